// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module      : fetch_stage_if
// Description : Bus bundle between the fetch stage and its environment
//               (hazard controls, redirect, imem load port, ID outputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if #(
   parameter int IMEM_AW = 8
);
   logic               PCWrite;
   logic               IFIDWrite;
   logic               brunch_control;
   logic               brunch_taken;
   logic [31:0]        BranchAddr;
   logic               jump;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_wdata;
   logic [31:0]        IFpc;
   logic [31:0]        IDpc_plus_4;
   logic [31:0]        IDinst;
   logic               IFflush;

   modport master (
      output PCWrite, IFIDWrite, brunch_control, brunch_taken, BranchAddr,
             jump, imem_we, imem_addr, imem_wdata,
      input  IFpc, IDpc_plus_4, IDinst, IFflush
   );

   modport slave (
      input  PCWrite, IFIDWrite, brunch_control, brunch_taken, BranchAddr,
             jump, imem_we, imem_addr, imem_wdata,
      output IFpc, IDpc_plus_4, IDinst, IFflush
   );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : PC register, word-addressed instruction memory and IF/ID
//               pipeline register with stall and branch/jump redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 256,
   parameter int          IMEM_AW    = 8
) (
   input  wire logic    clock,
   input  wire logic    reset,
   fetch_stage_if.slave bus
);

   logic [31:0] mem_q [IMEM_DEPTH];
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pp4_q, pp4_d;

   logic [31:0] w_if_inst;
   logic [31:0] w_if_pp4;
   logic [31:0] w_jump_target;
   logic [31:0] w_target;
   logic        w_br_redir;
   logic        w_redirect;
   logic        w_flush;
   logic        w_unused_pc_bits;

   // Only the word index of the PC addresses memory; the rest wraps away.
   assign w_if_inst        = mem_q[pc_q[IMEM_AW+1:2]];
   assign w_unused_pc_bits = ^{pc_q[31:IMEM_AW+2], pc_q[1:0]};
   assign w_if_pp4         = pc_q + 32'd4;

   assign w_br_redir    = bus.brunch_control & bus.brunch_taken;
   assign w_redirect    = w_br_redir | bus.jump;
   assign w_jump_target = {pp4_q[31:28], inst_q[25:0], 2'b00};
   assign w_target      = w_br_redir ? bus.BranchAddr : w_jump_target;
   // A stalled redirect is not acted on; the ID instruction re-evaluates.
   assign w_flush       = w_redirect & bus.PCWrite;

   always_comb begin
      pc_d   = pc_q;
      inst_d = inst_q;
      pp4_d  = pp4_q;
      if (bus.PCWrite) begin
         pc_d = w_redirect ? w_target : w_if_pp4;
      end
      if (w_flush) begin
         inst_d = 32'd0;
         pp4_d  = 32'd0;
      end else if (bus.IFIDWrite) begin
         inst_d = w_if_inst;
         pp4_d  = w_if_pp4;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         inst_q <= 32'd0;
         pp4_q  <= 32'd0;
      end else begin
         pc_q   <= pc_d;
         inst_q <= inst_d;
         pp4_q  <= pp4_d;
      end
   end

   // Writes proceed under reset so a program can be loaded before release.
   always_ff @(posedge clock) begin
      if (bus.imem_we) begin
         mem_q[bus.imem_addr] <= bus.imem_wdata;
      end
   end

   assign bus.IFpc        = pc_q;
   assign bus.IDinst      = inst_q;
   assign bus.IDpc_plus_4 = pp4_q;
   assign bus.IFflush     = w_flush;

endmodule

`default_nettype wire
